osc_wave_gen: RTL and testbench
===============================

# osc_wave_gen

Parametrised multi-waveform oscillator core. It replaces the fixed square and triangle generators in the datapath with a single block. It runs on the `divided_clk` tick produced by the note rate divider (one tick per waveform step). It produces square, pulse, sawtooth and triangle samples with selectable amplitude and duty, using a configurable number of steps per period. Mode, duty and amplitude changes and note-off take effect only at period boundaries, so the audio word sent to the codec path is glitch-free.

## Interface
- `WIDTH`, default 24: sample word width, matching the codec data width.
- `STEPS_LOG2`, default 3: log2 of steps per period. N = 2^STEPS_LOG2. Legal range is 2..8.

- `divided_clk`, in, 1: step clock.
- `reset_n`, in, 1: reset, synchronous, active-low; clock divided_clk.
- `enable`, in, 1: note gate; 1 = key held.
- `mode`, in, 2: waveform select. 00 square, 01 triangle, 10 sawtooth, 11 pulse.
- `duty`, in, STEPS_LOG2: number of high steps per period in pulse mode.
- `amplitude`, in, WIDTH: peak sample value.
- `wave_out`, out, WIDTH: registered sample.
- `period_start`, out, 1: high while `wave_out` holds the phase-0 sample.
- `active`, out, 1: high when the FSM is in RUN.

## Operation
- FSM states are IDLE and RUN.
- Phase counter p is STEPS_LOG2 bits wide and counts 0..N-1 modulo N.
- Shadow registers `mode_s`, `duty_s` and `amp_s` are used for all sample computation. Live inputs never feed the sample math directly.
- **IDLE:**
  - Each edge: `wave_out` <= 0, `period_start` <= 0.
  - If `enable`=1: latch the shadows from the inputs, p <= 0, go to RUN.
- **RUN**, each edge:
  - `wave_out` <= f(`mode_s`, p).
  - `period_start` <= (p==0).
  - p <= p+1.
- **RUN at the edge where p==N-1:**
  - If `enable`=1: latch the shadows and stay in RUN.
  - If `enable`=0: go to IDLE with p <= 0.
- Dropping `enable` mid-period never truncates the period.
- Re-asserting `enable` before the period ends cancels the stop.
- Waveform definitions, with H = N/2:
  - Square: `amp_s` if p<H, else 0.
  - Pulse: `amp_s` if p<`duty_s`, else 0. `duty_s`=0 gives constant 0.
  - Sawtooth: p * (`amp_s` >> STEPS_LOG2).
  - Triangle: p * (`amp_s` >> (STEPS_LOG2-1)) if p<=H, else (N-p) * (`amp_s` >> (STEPS_LOG2-1)).
- Arithmetic rules:
  - All arithmetic is unsigned.
  - Products are computed at WIDTH+STEPS_LOG2 bits, then truncated to WIDTH.
  - By construction, results are ≤ `amp_s`, so no overflow occurs.
  - Low bits lost by the right shift are discarded. Peaks may therefore fall slightly below `amp_s`.
- `active` = (state==RUN), decoded from a registered state bit.

## Timing
- Reset at the edge with `reset_n`=0:
  - State = IDLE, p=0.
  - Shadows = 0.
  - `wave_out`=0, `period_start`=0, `active`=0.
- Reset overrides everything and takes effect from any state or phase, mid-period included.
- Start latency: `enable` is sampled high at edge k (IDLE→RUN). The phase-0 sample appears on `wave_out` after edge k+1, with `period_start`=1 for that cycle.
- Steady-state period is exactly N `divided_clk` cycles. `period_start` pulses once every N cycles, one cycle wide.
- Parameter change: inputs sampled at the edge where p==N-1 govern the next period, starting with its phase-0 sample. Input changes at any other time are ignored until that edge.
- Stop timing: the last nonzero-capable sample is the p=N-1 sample. `wave_out` returns to 0 one edge after the FSM enters IDLE.
- Simultaneous events:
  - `enable` low together with a parameter change at p==N-1: the FSM goes to IDLE and the shadows are not updated.
  - `enable` high in IDLE together with reset: reset wins.

## Test plan
- **Square.** Setup: N=8, `amplitude`=24'h07FFFF, `mode`=00, `enable` held. Required: `wave_out` = 07FFFF ×4, 000000 ×4, repeating. `period_start` high on the first 07FFFF of each period.
- **Sawtooth.** Setup: `mode`=10, same amplitude. Required: `wave_out` = 0, 00FFFF, 01FFFE, …, 06FFF9, then wraps to 0.
- **Triangle.** Setup: `mode`=01. Required: 0, 01FFFF, 03FFFE, 05FFFD, 07FFFC, 05FFFD, 03FFFE, 01FFFF, repeating.
- **Pulse.**
  - `mode`=11, `duty`=2: 07FFFF ×2, then 0 ×6.
  - Change `duty` to 5 at p=3: no change until the next period, which shows 07FFFF ×5.
- **Gate release.** Drop `enable` at p=2. Required: the remaining samples for p=3..7 are emitted, then `active`=0 and `wave_out`=0. Re-raise `enable` at p=5 instead: the output continues without a break.
- **Reset mid-period.** Assert `reset_n`=0 at p=4 of a sawtooth. Required: at the next edge `wave_out`=0 and `active`=0. After release with `enable`=1, the phase-0 sample appears two edges later.

Source files
------------

// File: rtl/osc_wave_gen.sv
// ---------------------------------------------------------------------------
// osc_wave_gen
//
// Multi-waveform oscillator core stepped by the note-rate divider tick.
// Each divided_clk edge advances the phase by one step. A period is
// N = 2^STEPS_LOG2 steps. Square, triangle, sawtooth and pulse shapes are
// generated from shadow copies of mode, duty and amplitude. The shadows are
// reloaded only at the last step of a period, so the sample stream never
// changes shape mid-period.
//
// Parameters
//   WIDTH        sample word width (codec data width)
//   STEPS_LOG2   log2 of steps per period, legal range 2..8
//
// Ports
//   divided_clk   in   1           step clock
//   reset_n       in   1           synchronous active-low reset
//   enable        in   1           note gate, 1 = key held
//   mode          in   2           00 square, 01 triangle, 10 sawtooth, 11 pulse
//   duty          in   STEPS_LOG2  high steps per period in pulse mode
//   amplitude     in   WIDTH       peak sample value
//   wave_out      out  WIDTH       registered sample
//   period_start  out  1           high while wave_out holds the phase-0 sample
//   active        out  1           high while the FSM is in RUN
//
// State table
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | gate closed, output parked at 0, waiting for enable
//   ST_RUN   | stepping through the period, one sample per edge
// ---------------------------------------------------------------------------
module osc_wave_gen #(
    parameter int WIDTH      = 24,
    parameter int STEPS_LOG2 = 3
) (
    input  logic                  divided_clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [STEPS_LOG2-1:0] duty,
    input  logic [WIDTH-1:0]      amplitude,
    output logic [WIDTH-1:0]      wave_out,
    output logic                  period_start,
    output logic                  active
);

    localparam int N  = 1 << STEPS_LOG2;
    localparam int PW = WIDTH + STEPS_LOG2;

    localparam logic [STEPS_LOG2-1:0] PHASE_LAST = STEPS_LOG2'(N - 1);
    localparam logic [STEPS_LOG2-1:0] PHASE_HALF = STEPS_LOG2'(N / 2);
    localparam logic [STEPS_LOG2-1:0] PHASE_ONE  = STEPS_LOG2'(1);
    localparam logic [STEPS_LOG2:0]   PHASE_N    = (STEPS_LOG2 + 1)'(N);

    localparam logic [1:0] MODE_SQUARE   = 2'b00;
    localparam logic [1:0] MODE_TRIANGLE = 2'b01;
    localparam logic [1:0] MODE_SAWTOOTH = 2'b10;
    localparam logic [1:0] MODE_PULSE    = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [STEPS_LOG2-1:0]   phase;
    logic [STEPS_LOG2-1:0]   phase_nxt;
    logic                    load_shadow;
    logic [WIDTH-1:0]        wave_nxt;
    logic                    pstart_nxt;

    logic [1:0]              mode_s;
    logic [STEPS_LOG2-1:0]   duty_s;
    logic [WIDTH-1:0]        amp_s;

    // -----------------------------------------------------------------------
    // Sample math, driven only by the shadows and the phase counter
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0]        saw_step;
    logic [WIDTH-1:0]        tri_step;
    logic [STEPS_LOG2:0]     tri_idx;
    logic [PW-1:0]           saw_prod;
    logic [PW-1:0]           tri_prod;
    logic [WIDTH-1:0]        sample;
    logic                    unused_prod_hi;

    // Shifted step sizes guarantee p * step <= amp_s, so truncating the
    // wide product back to WIDTH never drops significant bits.
    assign saw_step = amp_s >> STEPS_LOG2;
    assign tri_step = amp_s >> (STEPS_LOG2 - 1);

    // Triangle rises for p = 0..H and mirrors down for p = H+1..N-1.
    // The extra bit holds N itself for the N - p fold.
    assign tri_idx  = (phase <= PHASE_HALF) ? {1'b0, phase}
                                            : PHASE_N - {1'b0, phase};

    assign saw_prod = PW'(phase)   * PW'(saw_step);
    assign tri_prod = PW'(tri_idx) * PW'(tri_step);

    assign unused_prod_hi = ^{saw_prod[PW-1:WIDTH], tri_prod[PW-1:WIDTH]};

    always_comb begin
        sample = '0;
        case (mode_s)
            MODE_SQUARE:   sample = (phase < PHASE_HALF) ? amp_s : '0;
            MODE_TRIANGLE: sample = tri_prod[WIDTH-1:0];
            MODE_SAWTOOTH: sample = saw_prod[WIDTH-1:0];
            MODE_PULSE:    sample = (phase < duty_s) ? amp_s : '0;
            default:       sample = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM next-state and registered-output values
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        load_shadow = 1'b0;
        wave_nxt    = '0;
        pstart_nxt  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (enable) begin
                    load_shadow = 1'b1;
                    phase_nxt   = '0;
                    state_nxt   = ST_RUN;
                end
            end

            ST_RUN: begin
                wave_nxt   = sample;
                pstart_nxt = (phase == '0);
                phase_nxt  = phase + PHASE_ONE;

                // The gate is only looked at on the last step, so a release
                // always finishes the period and a re-press before then is
                // simply never seen as a release.
                if (phase == PHASE_LAST) begin
                    if (enable) begin
                        load_shadow = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        phase_nxt = '0;
                    end
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                phase_nxt = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, phase and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge divided_clk) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            phase        <= '0;
            wave_out     <= '0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            phase        <= phase_nxt;
            wave_out     <= wave_nxt;
            period_start <= pstart_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Shadow registers
    // -----------------------------------------------------------------------
    always_ff @(posedge divided_clk) begin
        if (!reset_n) begin
            mode_s <= '0;
            duty_s <= '0;
            amp_s  <= '0;
        end else if (load_shadow) begin
            mode_s <= mode;
            duty_s <= duty;
            amp_s  <= amplitude;
        end
    end

    assign active = (state == ST_RUN);

endmodule

// File: tb/tb_osc_wave_gen.sv
// ---------------------------------------------------------------------------
// tb_osc_wave_gen
//
// Directed bench for osc_wave_gen with N = 8 and WIDTH = 24. Each vector
// holds the inputs applied before one divided_clk edge and the outputs
// expected just after that edge.
// ---------------------------------------------------------------------------
module tb_osc_wave_gen;

    localparam logic [23:0] A  = 24'h07FFFF;
    localparam logic [23:0] A2 = 24'h123456;

    localparam logic [23:0] SAW [8] = '{
        24'h000000, 24'h00FFFF, 24'h01FFFE, 24'h02FFFD,
        24'h03FFFC, 24'h04FFFB, 24'h05FFFA, 24'h06FFF9
    };
    localparam logic [23:0] TRI [8] = '{
        24'h000000, 24'h01FFFF, 24'h03FFFE, 24'h05FFFD,
        24'h07FFFC, 24'h05FFFD, 24'h03FFFE, 24'h01FFFF
    };

    typedef struct packed {
        logic [63:0] tag;
        logic        rst_n;
        logic        en;
        logic [1:0]  mode;
        logic [2:0]  duty;
        logic [23:0] amp;
        logic [23:0] exp_wave;
        logic        exp_ps;
        logic        exp_act;
    } vec_t;

    logic        divided_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [1:0]  mode;
    logic [2:0]  duty;
    logic [23:0] amplitude;
    logic [23:0] wave_out;
    logic        period_start;
    logic        active;

    int tests_run = 0;
    int failed    = 0;

    vec_t tbl[$];

    osc_wave_gen #(
        .WIDTH      (24),
        .STEPS_LOG2 (3)
    ) dut (
        .divided_clk  (divided_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .mode         (mode),
        .duty         (duty),
        .amplitude    (amplitude),
        .wave_out     (wave_out),
        .period_start (period_start),
        .active       (active)
    );

    always #5 divided_clk = ~divided_clk;

    function automatic vec_t mk(input logic [63:0] tag, input logic r, input logic e,
                                input logic [1:0] m, input logic [2:0] d,
                                input logic [23:0] a, input logic [23:0] w,
                                input logic ps, input logic act);
        vec_t v;
        v.tag      = tag;
        v.rst_n    = r;
        v.en       = e;
        v.mode     = m;
        v.duty     = d;
        v.amp      = a;
        v.exp_wave = w;
        v.exp_ps   = ps;
        v.exp_act  = act;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        reset_n   = v.rst_n;
        enable    = v.en;
        mode      = v.mode;
        duty      = v.duty;
        amplitude = v.amp;
        @(posedge divided_clk);
        #1;
        tests_run++;
        if (wave_out !== v.exp_wave || period_start !== v.exp_ps || active !== v.exp_act) begin
            failed++;
            $display("FAIL %0s: wave_out=%h want %h, period_start=%b want %b, active=%b want %b",
                     v.tag, wave_out, v.exp_wave, period_start, v.exp_ps, active, v.exp_act);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        mode      = 2'b00;
        duty      = 3'd0;
        amplitude = A;

        // Reset, then reset winning over enable, then start.
        tbl.push_back(mk("reset",   1'b0, 1'b0, 2'b00, 3'd0, A, 24'h0, 1'b0, 1'b0));
        tbl.push_back(mk("rst_en",  1'b0, 1'b1, 2'b00, 3'd0, A, 24'h0, 1'b0, 1'b0));
        tbl.push_back(mk("start",   1'b1, 1'b1, 2'b00, 3'd0, A, 24'h0, 1'b0, 1'b1));
        // Square; mode switches to sawtooth mid-period and must be ignored
        // until the p=7 edge.
        for (int p = 0; p < 8; p++)
            tbl.push_back(mk("square", 1'b1, 1'b1, (p >= 4) ? 2'b10 : 2'b00, 3'd0, A,
                             (p < 4) ? A : 24'h0, p == 0, 1'b1));
        for (int p = 0; p < 8; p++)
            tbl.push_back(mk("sawtooth", 1'b1, 1'b1, (p == 7) ? 2'b01 : 2'b10, 3'd0, A,
                             SAW[p], p == 0, 1'b1));
        for (int p = 0; p < 8; p++)
            tbl.push_back(mk("triangle", 1'b1, 1'b1, (p == 7) ? 2'b11 : 2'b01, 3'd2, A,
                             TRI[p], p == 0, 1'b1));

        for (int i = 0; i < tbl.size(); i++)
            run_vec(tbl[i]);

        // Pulse duty 2, with duty raised to 5 from p=3: only the next period
        // may show five high steps.
        for (int p = 0; p < 8; p++)
            run_vec(mk("pulse2", 1'b1, 1'b1, 2'b11, (p >= 3) ? 3'd5 : 3'd2, A,
                       (p < 2) ? A : 24'h0, p == 0, 1'b1));
        for (int p = 0; p < 8; p++)
            run_vec(mk("pulse5", 1'b1, 1'b1, (p == 7) ? 2'b10 : 2'b11, 3'd5, A,
                       (p < 5) ? A : 24'h0, p == 0, 1'b1));

        // Gate release at p=2 on a sawtooth: period completes, then idle.
        for (int p = 0; p < 8; p++)
            run_vec(mk("release", 1'b1, p < 2, 2'b10, 3'd5, A,
                       SAW[p], p == 0, p != 7));
        run_vec(mk("rel_zero", 1'b1, 1'b0, 2'b10, 3'd5, A, 24'h0, 1'b0, 1'b0));
        run_vec(mk("idle",     1'b1, 1'b0, 2'b10, 3'd5, A, 24'h0, 1'b0, 1'b0));
        run_vec(mk("restart",  1'b1, 1'b1, 2'b10, 3'd5, A, 24'h0, 1'b0, 1'b1));

        // Gate dropped at p=2 and re-raised at p=5: no break in the stream.
        for (int p = 0; p < 8; p++)
            run_vec(mk("reraise", 1'b1, (p < 2) || (p >= 5), 2'b10, 3'd5, A,
                       SAW[p], p == 0, 1'b1));

        // Reset at p=4 of a sawtooth, then restart.
        for (int p = 0; p < 4; p++)
            run_vec(mk("saw_pre", 1'b1, 1'b1, 2'b10, 3'd5, A, SAW[p], p == 0, 1'b1));
        run_vec(mk("rst_mid", 1'b0, 1'b1, 2'b10, 3'd5, A, 24'h0, 1'b0, 1'b0));
        run_vec(mk("rel_run", 1'b1, 1'b1, 2'b10, 3'd5, A, 24'h0, 1'b0, 1'b1));
        run_vec(mk("rel_p0",  1'b1, 1'b1, 2'b10, 3'd5, A, 24'h0, 1'b1, 1'b1));
        run_vec(mk("rel_p1",  1'b1, 1'b1, 2'b10, 3'd5, A, 24'h00FFFF, 1'b0, 1'b1));

        // Amplitude change from p=4 is held off; square at new amplitude
        // starts with the next period.
        for (int p = 2; p < 8; p++)
            run_vec(mk("amp_hold", 1'b1, 1'b1, (p == 7) ? 2'b00 : 2'b10, 3'd5,
                       (p >= 4) ? A2 : A, SAW[p], 1'b0, 1'b1));
        for (int p = 0; p < 8; p++)
            run_vec(mk("sq_amp", 1'b1, 1'b1, 2'b00, 3'd5, A2,
                       (p < 4) ? A2 : 24'h0, p == 0, 1'b1));

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
